qm_writeback: RTL and testbench
===============================

# qm_writeback

Writeback stage of the q3kmips pipeline, sitting after the memory stage and driving the register-file write port of `qm_decode` (`di_WA`/`di_WE`/`di_WD`). Each instruction is accepted once. The block selects between the ALU result and load data and produces a single-cycle register write strobe. When a load's data memory response is late, it stalls the memory stage with a ready/valid handshake. Writes to `$zero` are suppressed.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `di_Valid`  in  1  memory stage presents an instruction this cycle.
- `do_Ready`  out  1  writeback can accept; transfer occurs when `di_Valid && do_Ready`.
- `di_ALUResult`  in  32  ALU result of the presented instruction.
- `di_WA`  in  5  destination register (RegDest already resolved upstream).
- `ci_RegWrite`  in  1  instruction writes a register.
- `ci_RegWSource`  in  1  0 = ALU result, 1 = memory load data.
- `di_MemData`  in  32  data memory read data.
- `di_MemValid`  in  1  `di_MemData` is valid this cycle.
- `do_WA`  out  5  register write address, to decode.
- `do_WE`  out  1  register write enable, to decode; one-cycle pulse.
- `do_WD`  out  32  register write data, to decode.
- `do_Commit`  out  1  one-cycle pulse per completed instruction.
- `do_Retired`  out  32  retired-instruction count (only with `QM_WB_RETIRE_CNT_EN`).

## Operation
- States:
  - IDLE: `do_Ready`=1.
  - WAIT_MEM: `do_Ready`=0; `di_Valid` is ignored.
- IDLE, transfer with `ci_RegWrite`=0:
  - Next cycle: `do_Commit`=1, `do_WE`=0.
- IDLE, transfer with `ci_RegWrite`=1 and `ci_RegWSource`=0:
  - Next cycle: `do_WE`=(`di_WA`!=0), `do_WA`=`di_WA`, `do_WD`=`di_ALUResult`, `do_Commit`=1.
- IDLE, transfer with `ci_RegWrite`=1, `ci_RegWSource`=1 and `di_MemValid`=1:
  - Same as the ALU path, but `do_WD`=`di_MemData`.
- IDLE, transfer with `ci_RegWrite`=1, `ci_RegWSource`=1 and `di_MemValid`=0:
  - Latch `di_WA` and go to WAIT_MEM. No write yet.
- WAIT_MEM with `di_MemValid`=1:
  - Next cycle: write pulse using the latched WA and `di_MemData`, `do_Commit`=1, state returns to IDLE.
- WAIT_MEM with `di_MemValid`=0: remain in WAIT_MEM indefinitely.
- `di_MemValid` while in IDLE with no load transfer: ignored.
- `do_WA`/`do_WD` hold their last written values while `do_WE`=0.
- `do_WE` never stays high for two consecutive cycles from the same instruction.
- `di_WA`=0 suppresses `do_WE` only; the instruction still commits.

## Timing
- Reset values: state IDLE, `do_Ready`=1, `do_WE`=0, `do_WA`=0, `do_WD`=0, `do_Commit`=0, `do_Retired`=0.
- Latency from transfer to write pulse:
  - 1 cycle for ALU results and loads whose data arrives with the transfer.
  - 1 cycle after `di_MemValid` for late loads.
- Throughput: 1 instruction/cycle when there are no late loads.
- `do_Ready` is a registered state decode; it does not depend combinationally on `di_Valid`.
- Leaving WAIT_MEM:
  - The cycle after `di_MemValid`, `do_Ready`=1 and the write pulse is on `do_WE`.
  - A transfer in that cycle produces its own pulse one cycle later, back-to-back.
- Reset asserted in WAIT_MEM: the load is abandoned, no write occurs, and outputs immediately take their reset values.
- Reset asserted in the cycle after a transfer: the pending pulse is dropped.

## Configuration
- `QM_WB_RETIRE_CNT_EN` defined:
  - `do_Retired` is present as a 32-bit register.
  - It increments by 1 in every cycle `do_Commit`=1 and wraps from 0xFFFFFFFF to 0.
- `QM_WB_RETIRE_CNT_EN` undefined:
  - The `do_Retired` port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then transfer RegWrite=1, RegWSource=0, WA=5, ALUResult=0x12345678 -> next cycle `do_WE`=1, `do_WA`=5, `do_WD`=0x12345678, `do_Commit`=1; following cycle `do_WE`=0.
- Transfer load to WA=9 with `di_MemValid`=0, MemValid=1 with MemData=0xDEADBEEF three cycles later -> `do_Ready`=0 for exactly those cycles, then one pulse with WA=9, WD=0xDEADBEEF; `di_Valid` during the stall is not accepted.
- Transfer RegWrite=1 with WA=0, ALUResult=0xFFFFFFFF -> `do_WE`=0, `do_Commit`=1, `do_WD` unchanged.
- Back-to-back ALU transfers to WA=1,2,3 -> three consecutive WE pulses with matching WA/WD; store (RegWrite=0) in between -> commit without WE.
- Assert reset while in WAIT_MEM, then drive `di_MemValid`=1 -> no write pulse, `do_Ready`=1, all outputs zero.
- With `QM_WB_RETIRE_CNT_EN`, force count to 0xFFFFFFFE and commit 3 instructions -> `do_Retired` reads 0xFFFFFFFF, 0, 1.

Source files
------------

// File: rtl/qm_writeback.sv
// qm_writeback: writeback stage of the q3kmips pipeline.
// It accepts one instruction per cycle from the memory stage. For each one it
// picks the ALU result or the load data and emits a one-cycle register write
// pulse to decode. When load data arrives after the transfer, the stage holds
// do_Ready low until di_MemValid. Writes to $zero are suppressed, but the
// instruction still commits.
//
// Optional feature macro: QM_WB_RETIRE_CNT_EN adds the 32-bit do_Retired counter.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   di_Valid / do_Ready   ready/valid handshake with the memory stage
//   di_ALUResult, di_WA   ALU result and destination register
//   ci_RegWrite           instruction writes a register
//   ci_RegWSource         0 = ALU result, 1 = load data
//   di_MemData/MemValid   data memory read response
//   do_WA/do_WE/do_WD     register-file write port to decode
//   do_Commit             one-cycle pulse per completed instruction
//   do_Retired            retired-instruction count (QM_WB_RETIRE_CNT_EN only)
module qm_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        di_Valid,
    output logic        do_Ready,
    input  logic [31:0] di_ALUResult,
    input  logic [4:0]  di_WA,
    input  logic        ci_RegWrite,
    input  logic        ci_RegWSource,
    input  logic [31:0] di_MemData,
    input  logic        di_MemValid,
    output logic [4:0]  do_WA,
    output logic        do_WE,
    output logic [31:0] do_WD,
    output logic        do_Commit
`ifdef QM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0] do_Retired
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                commit_q, commit_d;
    logic [ADDR_W-1:0]   pend_wa_q, pend_wa_d;

    logic                xfer;
    logic                late_load;
    logic                wr_req;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    assign xfer      = di_Valid && ready_q;
    assign late_load = ci_RegWrite && ci_RegWSource && !di_MemValid;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            commit_q  <= 1'b0;
            pend_wa_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            commit_q  <= commit_d;
            pend_wa_q <= pend_wa_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (xfer && late_load) state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: if (di_MemValid)       state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output logic: build the registered write/commit values for next cycle
    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        we_d      = 1'b0;
        commit_d  = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;
        pend_wa_d = pend_wa_q;
        wr_req    = 1'b0;
        wr_addr   = di_WA;
        wr_data   = di_ALUResult;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (!ci_RegWrite) begin
                        commit_d = 1'b1;
                    end else if (!ci_RegWSource) begin
                        commit_d = 1'b1;
                        wr_req   = 1'b1;
                    end else if (di_MemValid) begin
                        commit_d = 1'b1;
                        wr_req   = 1'b1;
                        wr_data  = di_MemData;
                    end else begin
                        // Load data is late: remember the target and stall
                        pend_wa_d = di_WA;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (di_MemValid) begin
                    commit_d = 1'b1;
                    wr_req   = 1'b1;
                    wr_addr  = pend_wa_q;
                    wr_data  = di_MemData;
                end
            end
            default: ;
        endcase

        // $zero is never written; WA/WD keep their last written values
        if (wr_req && (wr_addr != '0)) begin
            we_d = 1'b1;
            wa_d = wr_addr;
            wd_d = wr_data;
        end
    end

    assign do_Ready  = ready_q;
    assign do_WE     = we_q;
    assign do_WA     = wa_q;
    assign do_WD     = wd_q;
    assign do_Commit = commit_q;

`ifdef QM_WB_RETIRE_CNT_EN
    logic [DATA_W-1:0] retired_q, retired_d;

    // Retired count advances on each commit pulse and wraps naturally
    always_comb begin
        retired_d = retired_q + DATA_W'(commit_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign do_Retired = retired_q;
`endif

endmodule

// File: tb/tb_qm_writeback.sv
// Testbench for qm_writeback: directed stimulus with a commit scoreboard.
module tb_qm_writeback;

    logic        clk;
    logic        reset;
    logic        di_Valid;
    logic        do_Ready;
    logic [31:0] di_ALUResult;
    logic [4:0]  di_WA;
    logic        ci_RegWrite;
    logic        ci_RegWSource;
    logic [31:0] di_MemData;
    logic        di_MemValid;
    logic [4:0]  do_WA;
    logic        do_WE;
    logic [31:0] do_WD;
    logic        do_Commit;
`ifdef QM_WB_RETIRE_CNT_EN
    logic [31:0] do_Retired;
    logic [31:0] ret_model;
`endif

    qm_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .di_Valid      (di_Valid),
        .do_Ready      (do_Ready),
        .di_ALUResult  (di_ALUResult),
        .di_WA         (di_WA),
        .ci_RegWrite   (ci_RegWrite),
        .ci_RegWSource (ci_RegWSource),
        .di_MemData    (di_MemData),
        .di_MemValid   (di_MemValid),
        .do_WA         (do_WA),
        .do_WE         (do_WE),
        .do_WD         (do_WD),
        .do_Commit     (do_Commit)
`ifdef QM_WB_RETIRE_CNT_EN
        ,
        .do_Retired    (do_Retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  exp_wa = '0;
    logic [31:0] exp_wd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Record the expected commit for a write (or no write) to wa with data d
    task automatic push_write(input logic [4:0] wa, input logic [31:0] d);
        exp_t e;
        if (wa != 5'd0) begin
            exp_wa = wa;
            exp_wd = d;
            e.we = 1'b1;
        end else begin
            e.we = 1'b0;
        end
        e.wa = exp_wa;
        e.wd = exp_wd;
        sb.push_back(e);
    endtask

    task automatic push_nowrite();
        exp_t e;
        e.we = 1'b0;
        e.wa = exp_wa;
        e.wd = exp_wd;
        sb.push_back(e);
    endtask

    // Present one instruction for one clock edge; leaves inputs driven
    task automatic send(input logic rw, input logic rws, input logic [4:0] wa,
                        input logic [31:0] alu, input logic mv, input logic [31:0] md);
        di_Valid      = 1'b1;
        ci_RegWrite   = rw;
        ci_RegWSource = rws;
        di_WA         = wa;
        di_ALUResult  = alu;
        di_MemValid   = mv;
        di_MemData    = md;
        chk("ready_on_send", 32'(do_Ready), 32'd1);
        if (!rw)            push_nowrite();
        else if (!rws)      push_write(wa, alu);
        else if (mv)        push_write(wa, md);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        di_Valid    = 1'b0;
        di_MemValid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: every commit pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
`ifdef QM_WB_RETIRE_CNT_EN
            ret_model = '0;
`endif
        end else begin
            if (do_WE && !do_Commit) begin
                n_cmp++;
                n_err++;
                $display("FAIL we_without_commit: got WE=1 Commit=0 expected WE only with Commit");
            end
            if (do_Commit) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_commit: got commit WE=%0b WA=%0d WD=0x%08h expected none",
                             do_WE, do_WA, do_WD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    if (do_WE !== e.we || do_WA !== e.wa || do_WD !== e.wd) begin
                        n_err++;
                        $display("FAIL commit: got WE=%0b WA=%0d WD=0x%08h expected WE=%0b WA=%0d WD=0x%08h",
                                 do_WE, do_WA, do_WD, e.we, e.wa, e.wd);
                    end
                end
            end
`ifdef QM_WB_RETIRE_CNT_EN
            chk("retired", do_Retired, ret_model);
            if (do_Commit) ret_model = ret_model + 32'd1;
`endif
        end
    end

    initial begin
        reset         = 1'b1;
        di_Valid      = 1'b0;
        di_ALUResult  = '0;
        di_WA         = '0;
        ci_RegWrite   = 1'b0;
        ci_RegWSource = 1'b0;
        di_MemData    = '0;
        di_MemValid   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  32'(do_Ready),  32'd1);
        chk("rst_we",     32'(do_WE),     32'd0);
        chk("rst_wa",     32'(do_WA),     32'd0);
        chk("rst_wd",     do_WD,          32'd0);
        chk("rst_commit", 32'(do_Commit), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();

        // ALU writeback, then WE must drop
        send(1'b1, 1'b0, 5'd5, 32'h1234_5678, 1'b0, 32'h0);
        idle();
        chk("alu_we_drop", 32'(do_WE), 32'd0);

        // Late load to WA=9; junk valid during stall must be ignored
        send(1'b1, 1'b1, 5'd9, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            di_Valid      = 1'b1;
            ci_RegWrite   = 1'b1;
            ci_RegWSource = 1'b0;
            di_WA         = 5'd4;
            di_ALUResult  = 32'hAAAA_AAAA;
            di_MemValid   = (i == 2);
            di_MemData    = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
            chk("stall_ready", 32'(do_Ready), 32'd0);
            if (i == 2) push_write(5'd9, 32'hDEAD_BEEF);
            @(posedge clk); #1;
        end
        di_Valid    = 1'b0;
        di_MemValid = 1'b0;
        chk("ready_after_load", 32'(do_Ready), 32'd1);
        idle();

        // Write to $zero: commits without WE, WD unchanged
        send(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        idle();

        // Back-to-back ALU writes, then a store
        send(1'b1, 1'b0, 5'd1, 32'h1111_1111, 1'b0, 32'h0);
        send(1'b1, 1'b0, 5'd2, 32'h2222_2222, 1'b0, 32'h0);
        send(1'b1, 1'b0, 5'd3, 32'h3333_3333, 1'b0, 32'h0);
        send(1'b0, 1'b0, 5'd7, 32'h7777_7777, 1'b0, 32'h0);
        idle();

        // Load with data arriving alongside the transfer
        send(1'b1, 1'b1, 5'd6, 32'h0, 1'b1, 32'hCAFE_F00D);
        idle();

        // Late load, then a transfer in the cycle WAIT_MEM is left
        send(1'b1, 1'b1, 5'd10, 32'h0, 1'b0, 32'h0);
        di_Valid    = 1'b0;
        di_MemValid = 1'b1;
        di_MemData  = 32'h0BAD_F00D;
        push_write(5'd10, 32'h0BAD_F00D);
        @(posedge clk); #1;
        send(1'b1, 1'b0, 5'd11, 32'h55AA_55AA, 1'b0, 32'h0);
        idle();

        // Reset while in WAIT_MEM abandons the load
        send(1'b1, 1'b1, 5'd12, 32'h0, 1'b0, 32'h0);
        idle();
        chk("wait_ready", 32'(do_Ready), 32'd0);
        reset = 1'b1;
        #2;
        chk("mid_rst_ready", 32'(do_Ready), 32'd1);
        chk("mid_rst_wa",    32'(do_WA),    32'd0);
        chk("mid_rst_wd",    do_WD,         32'd0);
        exp_wa = '0;
        exp_wd = '0;
        @(posedge clk); #1;
        reset       = 1'b0;
        di_MemValid = 1'b1;
        di_MemData  = 32'h1357_9BDF;
        @(posedge clk); #1;
        di_MemValid = 1'b0;
        @(negedge clk);
        chk("post_rst_we",     32'(do_WE),     32'd0);
        chk("post_rst_commit", 32'(do_Commit), 32'd0);
        chk("post_rst_wd",     do_WD,          32'd0);
        @(posedge clk); #1;

`ifdef QM_WB_RETIRE_CNT_EN
        // Counter wrap: preload near the top, then commit three stores
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        ret_model = 32'hFFFF_FFFE;
        send(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        send(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        send(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        idle();
        chk("retired_wrap", do_Retired, 32'h0000_0001);
`endif

        repeat (3) idle();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
